// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encodings, digit limits and limit lookup for the stopwatch core
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  localparam logic [3:0] LIM_UNITS = 4'd9;
  localparam logic [3:0] LIM_TENS  = 4'd5;

  // Even digits are units (mod 10), odd digits are tens (mod 6): ss, mm:ss, hh:mm:ss.
  function automatic logic [3:0] digit_limit(input int idx);
    return ((idx % 2) == 0) ? LIM_UNITS : LIM_TENS;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit with up/down ripple carry/borrow and saturating preload
module bcd_digit_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       dir,
  input  logic [3:0] limit,
  input  logic       cin,
  output logic       cout,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value
);

  // Carry (up) fires at the limit, borrow (down) fires at zero; both only when this digit steps.
  assign cout = cin && (dir ? (value == 4'd0) : (value == limit));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 4'd0;
    end else if (load) begin
      value <= (load_val > limit) ? limit : load_val;
    end else if (en && cin) begin
      if (dir) begin
        value <= (value == 4'd0) ? limit : (value - 4'd1);
      end else begin
        value <= (value == limit) ? 4'd0 : (value + 4'd1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_timer_core.sv
// rtl/stopwatch_timer_core.sv - stopwatch/timer core with prescaler, lap hold, up/down count; STOPWATCH_BLINK_EN adds pause blink
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_pulse,
  input  logic                    lap_pulse,
  input  logic                    count_down,
  input  logic                    load_en,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic [1:0]              state,
  output logic                    running,
  output logic                    done_pulse,
  output logic                    wrap_pulse,
  output logic                    blank
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [W-1:0]    count;
  logic [W-1:0]    lap_q;
  logic            dir_q;
  logic            done_q, wrap_q;
  logic            run_i, tick, hit_zero, cell_en, load, clr, lap_cap;
  logic [NUM_DIGITS:0] chain;

  assign run_i    = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = run_i && (presc_q == PRE_LAST);
  assign hit_zero = tick && dir_q && (count == '0);
  assign cell_en  = tick && !hit_zero;
  assign load     = (state_q == S_RESET) && load_en;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    lap_cap = 1'b0;
    case (state_q)
      S_RESET: if (start_pulse) state_d = S_RUN;
      S_RUN: begin
        if (start_pulse) begin
          state_d = S_PAUSE;
        end else if (lap_pulse) begin
          state_d = S_LAP;
          lap_cap = 1'b1;
        end
      end
      S_LAP: begin
        if (start_pulse)    state_d = S_PAUSE;
        else if (lap_pulse) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (start_pulse) begin
          state_d = S_RUN;
        end else if (lap_pulse) begin
          state_d = S_RESET;
          clr     = 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase
    // A countdown expiring stops the clock regardless of any button this cycle.
    if (hit_zero) state_d = S_PAUSE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Prescaler holds in pause so the sub-tick fraction survives a pause/resume.
  always_ff @(posedge clk) begin
    if (rst || clr || (state_q == S_RESET)) begin
      presc_q <= '0;
    end else if (run_i) begin
      presc_q <= tick ? '0 : (presc_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (state_q == S_RESET) dir_q <= count_down;
      done_q <= hit_zero;
      wrap_q <= tick && !dir_q && chain[NUM_DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr)   lap_q <= '0;
    else if (lap_cap) lap_q <= count;
  end

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (cell_en),
      .dir      (dir_q),
      .limit    (digit_limit(i)),
      .cin      (chain[i]),
      .cout     (chain[i+1]),
      .load     (load),
      .load_val (load_bcd[4*i +: 4]),
      .value    (count[4*i +: 4])
    );
  end

  assign disp_bcd   = (state_q == S_LAP) ? lap_q : count;
  assign state      = state_q;
  assign running    = run_i;
  assign done_pulse = done_q;
  assign wrap_pulse = wrap_q;

`ifdef STOPWATCH_BLINK_EN
  localparam int HALF = TICK_DIV / 2;
  localparam int BW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q != S_PAUSE)) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank = blink_q && (state_q == S_PAUSE);
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb/tb_stopwatch_timer_core.sv - table-driven scoreboard bench for stopwatch_timer_core (TICK_DIV=4, NUM_DIGITS=4)
module tb_stopwatch_timer_core;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pulse, lap_pulse, count_down, load_en;
  logic [15:0] load_bcd;
  logic [15:0] disp_bcd;
  logic [1:0]  state;
  logic        running, done_pulse, wrap_pulse, blank;

  always #5 clk = ~clk;

  stopwatch_timer_core #(.TICK_DIV(4), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pulse (start_pulse),
    .lap_pulse   (lap_pulse),
    .count_down  (count_down),
    .load_en     (load_en),
    .load_bcd    (load_bcd),
    .disp_bcd    (disp_bcd),
    .state       (state),
    .running     (running),
    .done_pulse  (done_pulse),
    .wrap_pulse  (wrap_pulse),
    .blank       (blank)
  );

  typedef struct {
    logic        rst, start, lap, ld, cd;
    logic [15:0] lbcd;
    int          wt;
    logic [15:0] e_disp;
    logic [1:0]  e_st;
    logic        e_wrap, e_done, blk;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] disp;
    logic [1:0]  st;
    logic        wrap, done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   wrap_cnt = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (wrap_pulse) wrap_cnt++;
    if (done_pulse) done_cnt++;
  end

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic l, input logic ld, input logic cd,
                     input logic [15:0] lb, input int wt, input logic [15:0] ed, input logic [1:0] es,
                     input logic ew, input logic edn, input logic blk);
    vec_t v;
    v.rst = r; v.start = s; v.lap = l; v.ld = ld; v.cd = cd; v.lbcd = lb; v.wt = wt;
    v.e_disp = ed; v.e_st = es; v.e_wrap = ew; v.e_done = edn; v.blk = blk;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        v;
    exp_t        e;
    logic        exp_run;
    logic        exp_b;
    rst = 1'b1; start_pulse = 1'b0; lap_pulse = 1'b0; count_down = 1'b0;
    load_en = 1'b0; load_bcd = 16'h0000;

    //  rst start lap ld  cd  load      wait disp      state    wrap done blink
    add(1, 0, 0, 0, 0, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000, 240, 16'h0100, S_RUN,   0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000,   0, 16'h0100, S_PAUSE, 0, 0, 1);
    add(0, 0, 0, 0, 0, 16'h0000,  31, 16'h0100, S_PAUSE, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h5959,   0, 16'h5959, S_RESET, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000,   4, 16'h0000, S_RUN,   1, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0000,   0, 16'h0000, S_RUN,   0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000,   0, 16'h0000, S_PAUSE, 0, 0, 0);
    add(0, 0, 1, 0, 1, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 0, 0, 1, 1, 16'h0002,   0, 16'h0002, S_RESET, 0, 0, 0);
    add(0, 1, 0, 0, 1, 16'h0000,   4, 16'h0001, S_RUN,   0, 0, 0);
    add(0, 0, 0, 0, 1, 16'h0000,   3, 16'h0000, S_RUN,   0, 0, 0);
    add(0, 0, 0, 0, 1, 16'h0000,   3, 16'h0000, S_PAUSE, 0, 1, 0);
    add(0, 0, 0, 0, 1, 16'h0000,   0, 16'h0000, S_PAUSE, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000,  20, 16'h0005, S_RUN,   0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000,   0, 16'h0005, S_LAP,   0, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0000,  10, 16'h0005, S_LAP,   0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000,   0, 16'h0008, S_RUN,   0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0000,   0, 16'h0008, S_PAUSE, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000,  28, 16'h0007, S_RUN,   0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000,   0, 16'h0007, S_LAP,   0, 0, 0);
    add(1, 0, 0, 0, 0, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 0, 0, 1, 1, 16'h0100,   0, 16'h0100, S_RESET, 0, 0, 0);
    add(0, 1, 0, 0, 1, 16'h0000,   4, 16'h0059, S_RUN,   0, 0, 0);
    add(1, 0, 0, 0, 0, 16'h0000,   0, 16'h0000, S_RESET, 0, 0, 0);
    add(0, 0, 0, 1, 0, 16'hFA7C,   0, 16'h5959, S_RESET, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; start_pulse = v.start; lap_pulse = v.lap;
      load_en = v.ld; count_down = v.cd; load_bcd = v.lbcd;
      e.idx = i; e.disp = v.e_disp; e.st = v.e_st; e.wrap = v.e_wrap; e.done = v.e_done;
      sb.push_back(e);
      @(negedge clk);
      rst = 1'b0; start_pulse = 1'b0; lap_pulse = 1'b0; load_en = 1'b0;
      repeat (v.wt) @(negedge clk);
      e = sb.pop_front();
      exp_run = (e.st == S_RUN) || (e.st == S_LAP);
      chk("disp_bcd", e.idx, disp_bcd, e.disp);
      chk("state", e.idx, {14'd0, state}, {14'd0, e.st});
      chk("running", e.idx, {15'd0, running}, {15'd0, exp_run});
      chk("wrap_pulse", e.idx, {15'd0, wrap_pulse}, {15'd0, e.wrap});
      chk("done_pulse", e.idx, {15'd0, done_pulse}, {15'd0, e.done});
      chk("blank", e.idx, {15'd0, blank}, 16'd0);
      if (v.blk) begin
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
`ifdef STOPWATCH_BLINK_EN
          exp_b = ((k >> 1) & 1) != 0;
`else
          exp_b = 1'b0;
`endif
          chk("blank_seq", k, {15'd0, blank}, {15'd0, exp_b});
        end
      end
    end

    chk("wrap_total", 0, wrap_cnt[15:0], 16'd1);
    chk("done_total", 0, done_cnt[15:0], 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
